// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file.
// Commits execute results (buffered in a small FIFO) and memory load results
// (higher priority, always accepted) through a single GPR write port. Serves
// decode with two write-first bypassed read ports and a per-register pending
// write scoreboard that raises DEC_HAZARD.
//
// Ports:
//   CLK, RSTN                  clock, synchronous active-low reset
//   EX_VALID/EX_READY          execute result handshake
//   EX_RESULT, EX_RD           execute result payload
//   MEM_VALID, MEM_RESULT, MEM_RD   load result (no backpressure)
//   RS1_/RS2_SEL, _USE, _DATA  decode read ports
//   ISSUE_VALID, ISSUE_RD      decode issue of a register-writing instruction
//   DEC_HAZARD                 decode must stall (combinational)
//   WB_VALID, WB_SEL, WB_DATA  registered retire strobe and payload
module wb_regfile #(
    parameter int unsigned XCNT       = 32,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     EX_VALID,
    output logic                     EX_READY,
    input  logic [XLEN-1:0]          EX_RESULT,
    input  logic [$clog2(XCNT)-1:0]  EX_RD,
    input  logic                     MEM_VALID,
    input  logic [XLEN-1:0]          MEM_RESULT,
    input  logic [$clog2(XCNT)-1:0]  MEM_RD,
    input  logic [$clog2(XCNT)-1:0]  RS1_SEL,
    input  logic [$clog2(XCNT)-1:0]  RS2_SEL,
    input  logic                     RS1_USE,
    input  logic                     RS2_USE,
    output logic [XLEN-1:0]          RS1_DATA,
    output logic [XLEN-1:0]          RS2_DATA,
    input  logic                     ISSUE_VALID,
    input  logic [$clog2(XCNT)-1:0]  ISSUE_RD,
    output logic                     DEC_HAZARD,
    output logic                     WB_VALID,
    output logic [$clog2(XCNT)-1:0]  WB_SEL,
    output logic [XLEN-1:0]          WB_DATA
);

    localparam int unsigned RW = $clog2(XCNT);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
    logic [RW-1:0]   fifo_rd   [FIFO_DEPTH];
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;

    logic            ret_valid;
    logic [RW-1:0]   ret_rd;
    logic [XLEN-1:0] ret_data;
    logic            ret_dec;

    logic [XLEN-1:0] gpr     [XCNT];
    logic [1:0]      cnt     [XCNT];
    logic [1:0]      cnt_nxt [XCNT];
    logic [1:0]      eff1;
    logic [1:0]      eff2;
    logic            issue_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign EX_READY   = !fifo_full;
    assign push       = EX_VALID && !fifo_full;

    // Write-port arbitration: loads first, then the FIFO head.
    always_comb begin
        ret_valid = 1'b0;
        ret_rd    = '0;
        ret_data  = '0;
        pop       = 1'b0;
        if (MEM_VALID) begin
            ret_valid = 1'b1;
            ret_rd    = MEM_RD;
            ret_data  = MEM_RESULT;
        end else if (!fifo_empty) begin
            ret_valid = 1'b1;
            ret_rd    = fifo_rd[rd_ptr[PW-1:0]];
            ret_data  = fifo_data[rd_ptr[PW-1:0]];
            pop       = 1'b1;
        end
    end

    // A retire only decrements a live counter; a zero counter is a protocol error and holds.
    assign ret_dec = ret_valid && (ret_rd != '0) && (cnt[ret_rd] != 2'd0);

    // Read ports with write-first bypass of the retiring value.
    always_comb begin
        RS1_DATA = gpr[RS1_SEL];
        RS2_DATA = gpr[RS2_SEL];
        if (ret_valid && ret_rd == RS1_SEL) RS1_DATA = ret_data;
        if (ret_valid && ret_rd == RS2_SEL) RS2_DATA = ret_data;
        if (RS1_SEL == '0) RS1_DATA = '0;
        if (RS2_SEL == '0) RS2_DATA = '0;
    end

    // Hazard uses the pending count net of this cycle's retire; saturation uses the raw count.
    always_comb begin
        eff1 = cnt[RS1_SEL] - 2'(ret_dec && ret_rd == RS1_SEL);
        eff2 = cnt[RS2_SEL] - 2'(ret_dec && ret_rd == RS2_SEL);
        DEC_HAZARD = (RS1_USE && RS1_SEL != '0 && eff1 != 2'd0)
                  || (RS2_USE && RS2_SEL != '0 && eff2 != 2'd0)
                  || (ISSUE_VALID && ISSUE_RD != '0 && cnt[ISSUE_RD] == 2'd3);
    end

    assign issue_ok = ISSUE_VALID && !DEC_HAZARD && (ISSUE_RD != '0);

    // Scoreboard next state: issue and retire to the same register cancel.
    always_comb begin
        for (int i = 0; i < XCNT; i++) begin
            cnt_nxt[i] = cnt[i];
            if (i != 0) begin
                if (issue_ok && ISSUE_RD == RW'(i) && !(ret_dec && ret_rd == RW'(i)))
                    cnt_nxt[i] = cnt[i] + 2'd1;
                else if (ret_dec && ret_rd == RW'(i) && !(issue_ok && ISSUE_RD == RW'(i)))
                    cnt_nxt[i] = cnt[i] - 2'd1;
            end
        end
    end

    // FIFO pointers.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // FIFO storage; contents are don't-care while empty.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_data[wr_ptr[PW-1:0]] <= EX_RESULT;
            fifo_rd[wr_ptr[PW-1:0]]   <= EX_RD;
        end
    end

    // GPR write port and scoreboard state.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            for (int i = 0; i < XCNT; i++) begin
                gpr[i] <= '0;
                cnt[i] <= 2'd0;
            end
        end else begin
            if (ret_valid && ret_rd != '0) gpr[ret_rd] <= ret_data;
            for (int i = 0; i < XCNT; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    // Registered retire strobe.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            WB_VALID <= 1'b0;
            WB_SEL   <= '0;
            WB_DATA  <= '0;
        end else begin
            WB_VALID <= ret_valid;
            if (ret_valid) begin
                WB_SEL  <= ret_rd;
                WB_DATA <= ret_data;
            end
        end
    end

    // Retiring to a register with nothing pending means the issue side lost track.
    always_ff @(posedge CLK) begin
        if (RSTN && ret_valid && ret_rd != '0)
            assert (cnt[ret_rd] != 2'd0)
            else $error("wb_regfile: retire to x%0d with no pending write", ret_rd);
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed table-driven bench for wb_regfile. Inputs are driven on the falling
// edge; outputs are sampled 1ns later, so combinational outputs reflect the
// current row and WB_* reflect the retire selected in the previous row.
module tb_wb_regfile;

    logic        CLK;
    logic        RSTN;
    logic        EX_VALID;
    logic        EX_READY;
    logic [31:0] EX_RESULT;
    logic [4:0]  EX_RD;
    logic        MEM_VALID;
    logic [31:0] MEM_RESULT;
    logic [4:0]  MEM_RD;
    logic [4:0]  RS1_SEL;
    logic [4:0]  RS2_SEL;
    logic        RS1_USE;
    logic        RS2_USE;
    logic [31:0] RS1_DATA;
    logic [31:0] RS2_DATA;
    logic        ISSUE_VALID;
    logic [4:0]  ISSUE_RD;
    logic        DEC_HAZARD;
    logic        WB_VALID;
    logic [4:0]  WB_SEL;
    logic [31:0] WB_DATA;

    wb_regfile #(.XCNT(32), .XLEN(32), .FIFO_DEPTH(2)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .EX_VALID(EX_VALID), .EX_READY(EX_READY), .EX_RESULT(EX_RESULT), .EX_RD(EX_RD),
        .MEM_VALID(MEM_VALID), .MEM_RESULT(MEM_RESULT), .MEM_RD(MEM_RD),
        .RS1_SEL(RS1_SEL), .RS2_SEL(RS2_SEL), .RS1_USE(RS1_USE), .RS2_USE(RS2_USE),
        .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD), .DEC_HAZARD(DEC_HAZARD),
        .WB_VALID(WB_VALID), .WB_SEL(WB_SEL), .WB_DATA(WB_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned rstn, exv, exres, exrd, memv, memres, memrd;
        int unsigned rs1s, rs1u, rs2s, rs2u, issv, issrd;
        int unsigned rdy, rs1d, rs2d, haz, wbv, wbsel, wbdat;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL row %0d %s: got %h want %h", row, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        RSTN        = v.rstn[0];
        EX_VALID    = v.exv[0];
        EX_RESULT   = 32'(v.exres);
        EX_RD       = 5'(v.exrd);
        MEM_VALID   = v.memv[0];
        MEM_RESULT  = 32'(v.memres);
        MEM_RD      = 5'(v.memrd);
        RS1_SEL     = 5'(v.rs1s);
        RS1_USE     = v.rs1u[0];
        RS2_SEL     = 5'(v.rs2s);
        RS2_USE     = v.rs2u[0];
        ISSUE_VALID = v.issv[0];
        ISSUE_RD    = 5'(v.issrd);
    endtask

    initial begin
        //          rstn exv exres        exrd memv memres       memrd rs1s u rs2s u iss rd   rdy rs1d         rs2d         haz wbv sel wbdat
        // reset state, then rd=5 through the FIFO path with bypass
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  5, 1, 0, 0, 0, 0,  1, 0,           0,           0, 0, 0,  0});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  0, 0, 0, 0, 1, 5,  1, 0,           0,           0, 0, 0,  0});
        vq.push_back('{1, 1, 'h1234,      5,  0, 0,           0,  5, 1, 0, 0, 0, 0,  1, 0,           0,           1, 0, 0,  0});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  5, 1, 0, 0, 0, 0,  1, 'h1234,      0,           0, 0, 0,  0});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  5, 1, 0, 0, 0, 0,  1, 'h1234,      0,           0, 1, 5,  'h1234});
        // retire to x0
        vq.push_back('{1, 1, 'hFFFFFFFF,  0,  0, 0,           0,  0, 1, 0, 0, 0, 0,  1, 0,           0,           0, 0, 0,  0});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  0, 1, 0, 0, 0, 0,  1, 0,           0,           0, 0, 0,  0});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  0, 1, 5, 1, 0, 0,  1, 0,           'h1234,      0, 1, 0,  'hFFFFFFFF});
        // issue 3,3,3,7,8,9
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  0, 0, 0, 0, 1, 3,  1, 0,           0,           0, 0, 0,  0});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  0, 0, 0, 0, 1, 3,  1, 0,           0,           0, 0, 0,  0});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  0, 0, 0, 0, 1, 3,  1, 0,           0,           0, 0, 0,  0});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  0, 0, 0, 0, 1, 7,  1, 0,           0,           0, 0, 0,  0});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  0, 0, 0, 0, 1, 8,  1, 0,           0,           0, 0, 0,  0});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  0, 0, 0, 0, 1, 9,  1, 0,           0,           0, 0, 0,  0});
        // MEM priority for 3 cycles while EX fills the FIFO and backs up
        vq.push_back('{1, 1, 'h70,        7,  1, 'hDEADBEEF,  3,  0, 0, 0, 0, 0, 0,  1, 0,           0,           0, 0, 0,  0});
        vq.push_back('{1, 1, 'h80,        8,  1, 'hDEADBEEF,  3,  3, 1, 0, 0, 0, 0,  1, 'hDEADBEEF,  0,           1, 1, 3,  'hDEADBEEF});
        vq.push_back('{1, 1, 'h90,        9,  1, 'hDEADBEEF,  3,  3, 1, 0, 0, 0, 0,  0, 'hDEADBEEF,  0,           0, 1, 3,  'hDEADBEEF});
        vq.push_back('{1, 1, 'h90,        9,  0, 0,           0,  7, 1, 0, 0, 0, 0,  0, 'h70,        0,           0, 1, 3,  'hDEADBEEF});
        vq.push_back('{1, 1, 'h90,        9,  0, 0,           0,  9, 1, 0, 0, 0, 0,  1, 0,           0,           1, 1, 7,  'h70});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  9, 1, 8, 1, 0, 0,  1, 'h90,        'h80,        0, 1, 8,  'h80});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  7, 1, 3, 1, 0, 0,  1, 'h70,        'hDEADBEEF,  0, 1, 9,  'h90});
        // RAW hazard on x4 clears in the retire cycle with bypass
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  0, 0, 0, 0, 1, 4,  1, 0,           0,           0, 0, 0,  0});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  4, 1, 0, 0, 0, 0,  1, 0,           0,           1, 0, 0,  0});
        vq.push_back('{1, 1, 'h4444,      4,  0, 0,           0,  4, 1, 0, 0, 0, 0,  1, 0,           0,           1, 0, 0,  0});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  4, 1, 0, 0, 0, 0,  1, 'h4444,      0,           0, 0, 0,  0});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  4, 1, 0, 0, 0, 0,  1, 'h4444,      0,           0, 1, 4,  'h4444});
        // x6 counter saturation, then drain
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  0, 0, 0, 0, 1, 6,  1, 0,           0,           0, 0, 0,  0});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  0, 0, 0, 0, 1, 6,  1, 0,           0,           0, 0, 0,  0});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  0, 0, 0, 0, 1, 6,  1, 0,           0,           0, 0, 0,  0});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  0, 0, 0, 0, 1, 6,  1, 0,           0,           1, 0, 0,  0});
        vq.push_back('{1, 1, 'h61,        6,  0, 0,           0,  0, 0, 0, 0, 1, 6,  1, 0,           0,           1, 0, 0,  0});
        vq.push_back('{1, 1, 'h62,        6,  0, 0,           0,  6, 1, 0, 0, 0, 0,  1, 'h61,        0,           1, 0, 0,  0});
        vq.push_back('{1, 1, 'h63,        6,  0, 0,           0,  6, 1, 0, 0, 0, 0,  1, 'h62,        0,           1, 1, 6,  'h61});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  6, 1, 0, 0, 0, 0,  1, 'h63,        0,           0, 1, 6,  'h62});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  6, 1, 0, 0, 1, 6,  1, 'h63,        0,           0, 1, 6,  'h63});
        // fill FIFO behind x0 loads, then reset mid-operation
        vq.push_back('{1, 1, 'hA1,        10, 1, 1,           0,  0, 0, 0, 0, 0, 0,  1, 0,           0,           0, 0, 0,  0});
        vq.push_back('{1, 1, 'hA2,        11, 1, 2,           0,  0, 0, 0, 0, 0, 0,  1, 0,           0,           0, 1, 0,  1});
        vq.push_back('{1, 1, 'hA3,        12, 1, 3,           0,  0, 0, 0, 0, 0, 0,  0, 0,           0,           0, 1, 0,  2});
        vq.push_back('{0, 1, 'hA3,        12, 0, 0,           0,  6, 1, 0, 0, 0, 0,  0, 'h63,        0,           1, 1, 0,  3});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  5, 1, 3, 1, 0, 0,  1, 0,           0,           0, 0, 0,  0});
        vq.push_back('{1, 0, 0,           0,  0, 0,           0,  6, 1, 7, 1, 0, 0,  1, 0,           0,           0, 0, 0,  0});

        RSTN = 1'b0; EX_VALID = 1'b0; EX_RESULT = '0; EX_RD = '0;
        MEM_VALID = 1'b0; MEM_RESULT = '0; MEM_RD = '0;
        RS1_SEL = '0; RS2_SEL = '0; RS1_USE = 1'b0; RS2_USE = 1'b0;
        ISSUE_VALID = 1'b0; ISSUE_RD = '0;
        repeat (2) @(posedge CLK);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge CLK);
            apply(vq[i]);
            #1;
            check("ex_ready",   i, 32'(EX_READY),   vq[i].rdy);
            check("rs1_data",   i, RS1_DATA,        vq[i].rs1d);
            check("rs2_data",   i, RS2_DATA,        vq[i].rs2d);
            check("dec_hazard", i, 32'(DEC_HAZARD), vq[i].haz);
            check("wb_valid",   i, 32'(WB_VALID),   vq[i].wbv);
            if (vq[i].wbv != 0) begin
                check("wb_sel",  i, 32'(WB_SEL), vq[i].wbsel);
                check("wb_data", i, WB_DATA,     vq[i].wbdat);
            end
        end

        // Hand sequence: x0 result travels through the FIFO within a bounded wait.
        @(negedge CLK);
        EX_VALID = 1'b1; EX_RESULT = 32'h0000_0055; EX_RD = 5'd0;
        RS1_SEL = 5'd0; RS1_USE = 1'b1; RS2_SEL = 5'd0; RS2_USE = 1'b0;
        @(negedge CLK);
        EX_VALID = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 5 && !seen; c++) begin
                #1;
                if (WB_VALID) seen = 1'b1;
                else @(negedge CLK);
            end
            check("x0_wb_seen", 100, 32'(seen), 32'd1);
            check("x0_wb_sel",  100, 32'(WB_SEL), 32'd0);
            check("x0_wb_data", 100, WB_DATA, 32'h0000_0055);
            check("x0_read",    100, RS1_DATA, 32'd0);
            check("x0_hazard",  100, 32'(DEC_HAZARD), 32'd0);
        end

        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
